// File: rtl/dmux_pkt_steer.sv
// Packet-level steering controller for a 1-to-2 stream demultiplexer.
// One registered holding stage; destination chosen at the first beat and locked until the last.
module dmux_pkt_steer #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out0_valid,
    output logic [DW-1:0] out0_data,
    output logic          out0_last,
    input  logic          out0_ready,
    output logic          out1_valid,
    output logic [DW-1:0] out1_data,
    output logic          out1_last,
    input  logic          out1_ready,
    output logic          sel,
    output logic          busy,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          hold_valid_q, hold_valid_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          hold_last_q, hold_last_d;
    logic          hold_dest_q, hold_dest_d;
    logic          sel_q, sel_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;

    logic drain;
    logic accept;
    logic dest;

    // The held beat carries its own destination, so only that output's ready matters.
    assign drain    = hold_valid_q && (hold_dest_q ? out1_ready : out0_ready);
    assign in_ready = !hold_valid_q || drain;
    assign accept   = in_valid && in_ready;
    assign dest     = (state_q == IDLE) ? (mode ? rr_ptr_q : in_data[0]) : sel_q;

    // FSM: state register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                IDLE:    if (!in_last) state_d = PKT;
                PKT:     if (in_last)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == PKT);
    end

    // Holding stage, destination lock and packet counters
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_dest_d  = hold_dest_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            hold_last_d  = in_last;
            hold_dest_d  = dest;
            if (state_q == IDLE) begin
                sel_d = dest;
                if (mode) rr_ptr_d = ~rr_ptr_q;
            end
            if (in_last) begin
                if (dest) cnt1_d = cnt1_q + CW'(1);
                else      cnt0_d = cnt0_q + CW'(1);
            end
        end else if (drain) begin
            hold_valid_d = 1'b0;
        end
    end

    // NOTE: the holding data register is reset too, so outputs read back zero
    // after reset rather than stale pre-reset data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_dest_q  <= 1'b0;
            sel_q        <= 1'b0;
            rr_ptr_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_dest_q  <= hold_dest_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign out0_valid = hold_valid_q && !hold_dest_q;
    assign out0_data  = hold_dest_q ? '0 : hold_data_q;
    assign out0_last  = hold_dest_q ? 1'b0 : hold_last_q;
    assign out1_valid = hold_valid_q && hold_dest_q;
    assign out1_data  = hold_dest_q ? hold_data_q : '0;
    assign out1_last  = hold_dest_q ? hold_last_q : 1'b0;
    assign sel        = sel_q;
    assign pkt_cnt0   = cnt0_q;
    assign pkt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_dmux_pkt_steer.sv
// Directed bench for dmux_pkt_steer: vector table plus hand-written reset and counter-wrap sequences.
// Counters are built 2 bits wide so wrap-around shows up in short runs.
module tb_dmux_pkt_steer;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          out0_valid;
    logic [DW-1:0] out0_data;
    logic          out0_last;
    logic          out0_ready;
    logic          out1_valid;
    logic [DW-1:0] out1_data;
    logic          out1_last;
    logic          out1_ready;
    logic          sel;
    logic          busy;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;

    dmux_pkt_steer #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .out1_ready (out1_ready),
        .sel        (sel),
        .busy       (busy),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs driven, in_ready expected before the edge, outputs expected after it.
    typedef struct {
        logic          rst;
        logic          mode;
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          r0;
        logic          r1;
        logic          e_rdy;
        logic          e_v0;
        logic          e_v1;
        logic [DW-1:0] e_d0;
        logic [DW-1:0] e_d1;
        logic          e_l0;
        logic          e_l1;
        logic          e_sel;
        logic          e_busy;
        logic [CW-1:0] e_c0;
        logic [CW-1:0] e_c1;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic m, input logic v, input logic [DW-1:0] d,
                         input logic l, input logic r0, input logic r1);
        mode       = m;
        in_valid   = v;
        in_data    = d;
        in_last    = l;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();
        step();
        check("rst_v0", 0, out0_valid, 0);
        check("rst_v1", 0, out1_valid, 0);
        check("rst_d0", 0, out0_data, 0);
        check("rst_d1", 0, out1_data, 0);
        check("rst_sel", 0, sel, 0);
        check("rst_busy", 0, busy, 0);
        check("rst_c0", 0, pkt_cnt0, 0);
        check("rst_c1", 0, pkt_cnt1, 0);
        rst = 1'b0;

        //               rst m  v  d      l  r0 r1  rdy v0 v1 d0     d1     l0 l1 sel bsy c0 c1
        // header steer
        vecs.push_back('{0, 0, 1, 8'h03, 0, 1, 1,  1,  0, 1, 8'h00, 8'h03, 0, 0, 1,  1,  0, 0});
        vecs.push_back('{0, 0, 1, 8'hAA, 0, 1, 1,  1,  0, 1, 8'h00, 8'hAA, 0, 0, 1,  1,  0, 0});
        vecs.push_back('{0, 0, 1, 8'hBB, 1, 1, 1,  1,  0, 1, 8'h00, 8'hBB, 0, 1, 1,  0,  0, 1});
        vecs.push_back('{0, 0, 1, 8'h02, 0, 1, 1,  1,  1, 0, 8'h02, 8'h00, 0, 0, 0,  1,  0, 1});
        vecs.push_back('{0, 0, 1, 8'h11, 1, 1, 1,  1,  1, 0, 8'h11, 8'h00, 1, 0, 0,  0,  1, 1});
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 1,  1,  0, 0, 8'h00, 8'h00, 0, 0, 0,  0,  1, 1});
        // reset, then round-robin with mode toggled on continuation beats
        vecs.push_back('{1, 0, 0, 8'h00, 0, 1, 1,  1,  0, 0, 8'h00, 8'h00, 0, 0, 0,  0,  0, 0});
        vecs.push_back('{0, 1, 1, 8'hA0, 0, 1, 1,  1,  1, 0, 8'hA0, 8'h00, 0, 0, 0,  1,  0, 0});
        vecs.push_back('{0, 0, 1, 8'hA1, 1, 1, 1,  1,  1, 0, 8'hA1, 8'h00, 1, 0, 0,  0,  1, 0});
        vecs.push_back('{0, 1, 1, 8'hB0, 0, 1, 1,  1,  0, 1, 8'h00, 8'hB0, 0, 0, 1,  1,  1, 0});
        vecs.push_back('{0, 0, 1, 8'hB0, 1, 1, 1,  1,  0, 1, 8'h00, 8'hB0, 0, 1, 1,  0,  1, 1});
        vecs.push_back('{0, 1, 1, 8'hC1, 0, 1, 1,  1,  1, 0, 8'hC1, 8'h00, 0, 0, 0,  1,  1, 1});
        vecs.push_back('{0, 1, 1, 8'hC2, 1, 1, 1,  1,  1, 0, 8'hC2, 8'h00, 1, 0, 0,  0,  2, 1});
        vecs.push_back('{0, 1, 1, 8'hD0, 0, 1, 1,  1,  0, 1, 8'h00, 8'hD0, 0, 0, 1,  1,  2, 1});
        vecs.push_back('{0, 1, 1, 8'hD1, 1, 1, 1,  1,  0, 1, 8'h00, 8'hD1, 0, 1, 1,  0,  2, 2});
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 1,  1,  0, 0, 8'h00, 8'h00, 0, 0, 1,  0,  2, 2});
        // backpressure on out1 for 5 cycles, out0_ready toggling
        vecs.push_back('{0, 0, 1, 8'h05, 0, 1, 0,  1,  0, 1, 8'h00, 8'h05, 0, 0, 1,  1,  2, 2});
        vecs.push_back('{0, 0, 1, 8'h06, 0, 0, 0,  0,  0, 1, 8'h00, 8'h05, 0, 0, 1,  1,  2, 2});
        vecs.push_back('{0, 0, 1, 8'h06, 0, 1, 0,  0,  0, 1, 8'h00, 8'h05, 0, 0, 1,  1,  2, 2});
        vecs.push_back('{0, 0, 1, 8'h06, 0, 0, 0,  0,  0, 1, 8'h00, 8'h05, 0, 0, 1,  1,  2, 2});
        vecs.push_back('{0, 0, 1, 8'h06, 0, 1, 0,  0,  0, 1, 8'h00, 8'h05, 0, 0, 1,  1,  2, 2});
        vecs.push_back('{0, 0, 1, 8'h06, 0, 1, 1,  1,  0, 1, 8'h00, 8'h06, 0, 0, 1,  1,  2, 2});
        vecs.push_back('{0, 0, 1, 8'h07, 1, 1, 1,  1,  0, 1, 8'h00, 8'h07, 0, 1, 1,  0,  2, 3});
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 1,  1,  0, 0, 8'h00, 8'h00, 0, 0, 1,  0,  2, 3});
        // single-beat packets back to back, counters wrap at 2 bits
        vecs.push_back('{0, 0, 1, 8'h00, 1, 1, 1,  1,  1, 0, 8'h00, 8'h00, 1, 0, 0,  0,  3, 3});
        vecs.push_back('{0, 0, 1, 8'h01, 1, 1, 1,  1,  0, 1, 8'h00, 8'h01, 0, 1, 1,  0,  3, 0});
        vecs.push_back('{0, 0, 1, 8'h00, 1, 1, 1,  1,  1, 0, 8'h00, 8'h00, 1, 0, 0,  0,  0, 0});
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 1,  1,  0, 0, 8'h00, 8'h00, 0, 0, 0,  0,  0, 0});

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            drive(vecs[i].mode, vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r0, vecs[i].r1);
            #1;
            check("in_ready", i, in_ready, vecs[i].e_rdy);
            step();
            check("out0_valid", i, out0_valid, vecs[i].e_v0);
            check("out1_valid", i, out1_valid, vecs[i].e_v1);
            if (vecs[i].e_v0 || vecs[i].e_v1) begin
                check("out0_data", i, out0_data, vecs[i].e_d0);
                check("out1_data", i, out1_data, vecs[i].e_d1);
                check("out0_last", i, out0_last, vecs[i].e_l0);
                check("out1_last", i, out1_last, vecs[i].e_l1);
            end
            check("sel", i, sel, vecs[i].e_sel);
            check("busy", i, busy, vecs[i].e_busy);
            check("pkt_cnt0", i, pkt_cnt0, vecs[i].e_c0);
            check("pkt_cnt1", i, pkt_cnt1, vecs[i].e_c1);
            rst = 1'b0;
        end

        // Reset mid-packet with a held beat: outputs clear at once, next beat is a header.
        do_reset();
        drive(1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step();
        check("mid_hold_v1", 0, out1_valid, 1);
        check("mid_busy", 0, busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_v0", 0, out0_valid, 0);
        check("async_v1", 0, out1_valid, 0);
        check("async_d1", 0, out1_data, 0);
        check("async_busy", 0, busy, 0);
        check("async_sel", 0, sel, 0);
        check("async_c0", 0, pkt_cnt0, 0);
        check("async_c1", 0, pkt_cnt1, 0);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1);
        #1;
        check("post_rst_rdy", 0, in_ready, 1);
        step();
        check("post_rst_v0", 0, out0_valid, 1);
        check("post_rst_v1", 0, out1_valid, 0);
        check("post_rst_d0", 0, out0_data, 8'h02);
        check("post_rst_c0", 0, pkt_cnt0, 1);
        check("post_rst_busy", 0, busy, 0);

        // Counter wrap: five single-beat packets to out0.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            int exp_cnt;
            exp_cnt = (k + 1) % 4;
            drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
            step();
            check("wrap_c0", k, pkt_cnt0, exp_cnt);
            check("wrap_c1", k, pkt_cnt1, 0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmux_pkt_steer.md
Name: dmux_pkt_steer

Overview:
- Packet-level steering controller for the 1-to-2 demultiplexer: accepts one valid/ready input stream and routes each whole packet to output 0 or output 1.
- Destination is chosen at the first beat of each packet and locked until the last beat.
- A single registered holding stage isolates input timing from the destinations.
- Sits between a stream source and two consumers; the `sel` output is also exported, so a plain DMUX can be driven in lock-step.

Parameters:
- DW, 8, data width in bits (DW >= 1).
- CW, 8, width of each per-output packet counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = header-steered, 1 = round-robin; sampled only at packet start
- in_valid  in  1  input beat valid
- in_data  in  DW  input beat data
- in_last  in  1  final beat of packet
- in_ready  out  1  input beat accepted when in_valid && in_ready
- out0_valid  out  1  beat valid on output 0
- out0_data  out  DW  output 0 data
- out0_last  out  1  output 0 last
- out0_ready  in  1  output 0 consumer ready
- out1_valid  out  1  beat valid on output 1
- out1_data  out  DW  output 1 data
- out1_last  out  1  output 1 last
- out1_ready  in  1  output 1 consumer ready
- sel  out  1  destination of packet in progress, or of the most recent packet
- busy  out  1  1 while mid-packet (state PKT)
- pkt_cnt0  out  CW  packets fully accepted for output 0
- pkt_cnt1  out  CW  packets fully accepted for output 1

Behaviour:

Reset (async, immediate):
- State IDLE; holding register empty (hold_valid=0); hold_data=0; hold_last=0; hold_dest=0.
- sel=0, busy=0, rr_ptr=0, pkt_cnt0=0, pkt_cnt1=0.
- Hence all outN_valid=0 and all data/last outputs are 0.
- A reset asserted mid-packet discards the packet and any held beat. No partial output follows reset deassertion.

Holding stage:
- outK_valid = hold_valid && (hold_dest==K).
- outK_data and outK_last = hold_data and hold_last when hold_dest==K, else 0.
- drain = hold_valid && ready of hold_dest.
- in_ready = !hold_valid || drain (combinational). A simultaneous drain and accept sustains 1 beat/cycle.
- An accepted beat loads the holding register at the next edge with its destination. Latency is exactly 1 cycle from input accept to outK_valid.
- If drain occurs without an accept, hold_valid clears.
- An output's ready is ignored while that output is not the holding destination.

Destination decision (on an accepted beat in IDLE only):
- mode=0: dest = in_data[0]. The header beat is forwarded unchanged as data.
- mode=1: dest = rr_ptr, then rr_ptr toggles.
- sel <= dest at that edge. In PKT, dest = sel; mode changes are ignored.

FSM:
- IDLE -> PKT on an accepted beat with in_last=0.
- IDLE -> IDLE on an accepted beat with in_last=1 (single-beat packet). sel still updates and the counter still increments.
- PKT -> IDLE on an accepted beat with in_last=1.
- Otherwise hold state.
- busy = (state==PKT).

Counters:
- pkt_cntK increments by 1 at the edge where a last beat destined to K is accepted at the input.
- Counters wrap modulo 2^CW with no saturation or flag.

Boundaries:
- No input beat is ever dropped or duplicated.
- Back-to-back packets to different destinations need no idle cycle. The holding register carries its own dest, so sel may change while the previous packet's last beat is still held.
- in_valid without in_ready: the beat is held by the source and no state changes.

Test Plan:
- Reset: assert rst mid-packet with hold_valid=1 -> immediately outN_valid=0, busy=0, sel=0, counters 0. After release, next beat is treated as a header.
- Header steer: mode=0, both readies 1, send packet {0x03,0xAA,0xBB(last)} -> three beats on out1 at cycles accept+1 in order, out0_valid never 1, pkt_cnt1=1. Then send {0x02,0x11(last)} -> out0, pkt_cnt0=1.
- Round-robin: mode=1, four 2-beat packets -> destinations 0,1,0,1. Toggling mode mid-packet has no effect. Final pkt_cnt0=2, pkt_cnt1=2.
- Backpressure: packet to out1 with out1_ready=0 for 5 cycles -> in_ready=0 after the first accept, held beat stable. out0_ready toggling has no effect. Release -> in_ready=1 the same cycle and the stream resumes at 1 beat/cycle.
- Single-beat back-to-back: mode=0, continuous last-beats with data 0x00,0x01,0x00 -> outputs alternate 0,1,0 with no bubbles, busy stays 0.
- Counter wrap: CW=2, five packets to out0 -> pkt_cnt0 sequence 1,2,3,0,1.
